// File: rtl/jimmy_loader_pkg.sv
// Shared definitions for the Jimmy program loader.
// Provides the FSM state encoding, the default parameter values and a
// helper that sizes counters.
package jimmy_loader_pkg;

  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_TIMEOUT        = 255;
  localparam int DEF_RELEASE_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/jimmy_loader_timer.sv
// Down-counter shared by the loader for the byte timeout and the CPU
// release hold.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : force count to zero (highest priority after reset)
//   load       : load load_val
//   load_val   : value to load
//   en         : decrement by one (stops at zero)
//   tc         : terminal count, high while count is zero
module jimmy_loader_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/jimmy_prog_loader.sv
// Jimmy program loader: receives a byte stream, writes it into program
// memory, verifies a trailing checksum byte and then releases the CPU.
// Ports:
//   jimmy_clk, reset            : clock, synchronous active-high reset
//   load_start, load_len        : load request and byte count (0 = 2**ADDR_W)
//   byte_in, byte_valid         : incoming byte stream
//   byte_ready                  : loader accepts a byte this cycle
//   pm_we, pm_addr, pm_wdata    : program memory write port (registered)
//   cpu_run                     : CPU may execute
//   load_done, load_err         : result of the last load
//   state_o                     : current FSM state
//
// state   | meaning
// IDLE    | after reset, waiting for load_start
// LOAD    | accepting program bytes and writing program memory
// CHECK   | waiting for the checksum byte
// RELEASE | checksum good, CPU still held for RELEASE_CYCLES
// RUN     | CPU running, load_done set
// ERROR   | checksum mismatch or timeout, load_err set
module jimmy_prog_loader
  import jimmy_loader_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT        = DEF_TIMEOUT,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
  input  logic              jimmy_clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err,
  output logic [2:0]        state_o
);

  localparam int TMR_W = cnt_width((TIMEOUT > RELEASE_CYCLES) ? TIMEOUT : RELEASE_CYCLES);

  state_t            state, state_next;
  logic              xfer, start_ok, last_byte, sum_ok;
  logic [ADDR_W-1:0] addr, len_last;
  logic [DATA_W-1:0] checksum;

  logic              tmr_clear, tmr_load, tmr_en, tmr_tc;
  logic [TMR_W-1:0]  tmr_load_val;

  assign xfer      = byte_valid & byte_ready;
  assign start_ok  = load_start &
                     ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERROR));
  // addr doubles as the byte count; len_last = load_len-1 wraps so 0 means full range
  assign last_byte = (addr == len_last);
  assign sum_ok    = (byte_in == checksum);
  assign state_o   = state;

  always_ff @(posedge jimmy_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // The timer is preloaded with N-1 so tc marks the N-th cycle itself.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_RUN, ST_ERROR: if (start_ok) state_next = ST_LOAD;
      ST_LOAD: begin
        if (xfer) begin
          if (last_byte) state_next = ST_CHECK;
        end else if (tmr_tc) begin
          state_next = ST_ERROR;
        end
      end
      ST_CHECK: begin
        if (xfer)        state_next = sum_ok ? ST_RELEASE : ST_ERROR;
        else if (tmr_tc) state_next = ST_ERROR;
      end
      ST_RELEASE: if (tmr_tc) state_next = ST_RUN;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready   = (state == ST_LOAD) || (state == ST_CHECK);
    cpu_run      = (state == ST_RUN);
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_load_val = TMR_W'(TIMEOUT - 1);
    tmr_clear    = (state_next != state) &&
                   ((state_next == ST_RUN) || (state_next == ST_ERROR));
    case (state)
      ST_IDLE, ST_RUN, ST_ERROR: tmr_load = start_ok;
      ST_LOAD: begin
        tmr_load = xfer;
        tmr_en   = ~xfer;
      end
      ST_CHECK: begin
        tmr_load = xfer;
        tmr_en   = ~xfer;
        if (xfer && sum_ok) tmr_load_val = TMR_W'(RELEASE_CYCLES - 1);
      end
      ST_RELEASE: tmr_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge jimmy_clk) begin
    if (reset) begin
      addr      <= '0;
      len_last  <= '0;
      checksum  <= '0;
      pm_we     <= 1'b0;
      pm_addr   <= '0;
      pm_wdata  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      pm_we <= 1'b0;
      if (start_ok) begin
        len_last  <= load_len - ADDR_W'(1);
        addr      <= '0;
        checksum  <= '0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end
      if ((state == ST_LOAD) && xfer) begin
        pm_we    <= 1'b1;
        pm_addr  <= addr;
        pm_wdata <= byte_in;
        addr     <= addr + ADDR_W'(1);
        checksum <= checksum + byte_in;
      end
      if ((state_next == ST_RUN) && (state != ST_RUN))     load_done <= 1'b1;
      if ((state_next == ST_ERROR) && (state != ST_ERROR)) load_err  <= 1'b1;
    end
  end

  jimmy_loader_timer #(.W(TMR_W)) u_timer (
    .clk      (jimmy_clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

endmodule

// File: tb/tb_jimmy_prog_loader.sv
// Directed bench for jimmy_prog_loader; expected program memory writes
// are queued as bytes are sent and popped when pm_we is seen.
module tb_jimmy_prog_loader;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          jimmy_clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_len = '0;
  logic [DW-1:0] byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, pm_we, cpu_run, load_done, load_err;
  logic [AW-1:0] pm_addr;
  logic [DW-1:0] pm_wdata;
  logic [2:0]    state_o;

  always #5 jimmy_clk = ~jimmy_clk;

  jimmy_prog_loader dut (
    .jimmy_clk  (jimmy_clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_err   (load_err),
    .state_o    (state_o)
  );

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_CHECK = 3'd2,
                         S_REL = 3'd3, S_RUN = 3'd4, S_ERR = 3'd5;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_writes = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; any pm_we seen
  // must match the oldest queued write.
  task automatic tick();
    logic [AW+DW-1:0] e;
    @(posedge jimmy_clk);
    #1;
    if (pm_we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("pm_we_spurious", 32'(pm_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pm_addr", 32'(pm_addr), 32'(e[AW+DW-1:DW]));
        chk("pm_wdata", 32'(pm_wdata), 32'(e[DW-1:0]));
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] b, input bit is_load);
    byte_in    = b;
    byte_valid = 1'b1;
    chk("byte_ready", 32'(byte_ready), 32'd1);
    if (is_load) begin
      exp_q.push_back({exp_addr, b});
      exp_addr = exp_addr + 1'b1;
    end
    tick();
    byte_valid = 1'b0;
    if (is_load) chk("pm_we_latency", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic start_load(input logic [AW-1:0] len);
    load_len   = len;
    load_start = 1'b1;
    exp_addr   = '0;
    tick();
    load_start = 1'b0;
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (state_o == S_REL && n < 20) begin
      chk("cpu_run_in_release", 32'(cpu_run), 32'd0);
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int w0;

    // reset values
    tick();
    tick();
    chk("rst_state", 32'(state_o), 32'(S_IDLE));
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_pm_we", 32'(pm_we), 32'd0);
    chk("rst_pm_addr", 32'(pm_addr), 32'd0);
    chk("rst_pm_wdata", 32'(pm_wdata), 32'd0);
    chk("rst_done_err", 32'({load_done, load_err}), 32'd0);
    reset = 1'b0;
    tick();

    // good 3-byte load
    w0 = n_writes;
    start_load(8'd3);
    chk("t1_state_load", 32'(state_o), 32'(S_LOAD));
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    chk("t1_state_check", 32'(state_o), 32'(S_CHECK));
    send(8'h06, 1'b0);
    chk("t1_state_release", 32'(state_o), 32'(S_REL));
    wait_release(n);
    chk("t1_release_cycles", 32'(n), 32'd4);
    chk("t1_state_run", 32'(state_o), 32'(S_RUN));
    chk("t1_cpu_run", 32'(cpu_run), 32'd1);
    chk("t1_load_done", 32'(load_done), 32'd1);
    chk("t1_load_err", 32'(load_err), 32'd0);
    chk("t1_writes", 32'(n_writes - w0), 32'd3);

    // restart from RUN, ignored load_start in LOAD, bad checksum
    w0 = n_writes;
    start_load(8'd3);
    chk("t2_state_load", 32'(state_o), 32'(S_LOAD));
    chk("t2_cpu_run_low", 32'(cpu_run), 32'd0);
    chk("t2_done_cleared", 32'(load_done), 32'd0);
    send(8'h01, 1'b1);
    load_start = 1'b1;
    load_len   = 8'd9;
    tick();
    load_start = 1'b0;
    chk("t2_start_ignored", 32'(state_o), 32'(S_LOAD));
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    chk("t2_state_check", 32'(state_o), 32'(S_CHECK));
    send(8'h07, 1'b0);
    chk("t2_state_err", 32'(state_o), 32'(S_ERR));
    chk("t2_load_err", 32'(load_err), 32'd1);
    chk("t2_load_done", 32'(load_done), 32'd0);
    tick();
    tick();
    chk("t2_cpu_run", 32'(cpu_run), 32'd0);
    chk("t2_writes", 32'(n_writes - w0), 32'd3);

    // timeout after 2nd byte
    w0 = n_writes;
    start_load(8'd5);
    chk("t3_err_cleared", 32'(load_err), 32'd0);
    send(8'h10, 1'b1);
    send(8'h20, 1'b1);
    n = 0;
    while (state_o == S_LOAD && n < 400) begin
      tick();
      n++;
    end
    chk("t3_idle_cycles", 32'(n), 32'd255);
    chk("t3_state_err", 32'(state_o), 32'(S_ERR));
    chk("t3_load_err", 32'(load_err), 32'd1);
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    repeat (5) tick();
    byte_valid = 1'b0;
    chk("t3_writes", 32'(n_writes - w0), 32'd2);

    // full 256-byte load with wrapping checksum
    w0 = n_writes;
    start_load(8'd0);
    for (int i = 0; i < 256; i++) send(8'h01, 1'b1);
    chk("t4_state_check", 32'(state_o), 32'(S_CHECK));
    send(8'h00, 1'b0);
    wait_release(n);
    chk("t4_release_cycles", 32'(n), 32'd4);
    chk("t4_state_run", 32'(state_o), 32'(S_RUN));
    chk("t4_load_done", 32'(load_done), 32'd1);
    chk("t4_writes", 32'(n_writes - w0), 32'd256);

    // reset mid-load, and reset beating load_start
    w0 = n_writes;
    start_load(8'd5);
    send(8'hA1, 1'b1);
    send(8'hA2, 1'b1);
    reset = 1'b1;
    tick();
    chk("t5_state", 32'(state_o), 32'(S_IDLE));
    chk("t5_pm_we", 32'(pm_we), 32'd0);
    chk("t5_pm_addr", 32'(pm_addr), 32'd0);
    chk("t5_pm_wdata", 32'(pm_wdata), 32'd0);
    chk("t5_cpu_run", 32'(cpu_run), 32'd0);
    chk("t5_byte_ready", 32'(byte_ready), 32'd0);
    chk("t5_done_err", 32'({load_done, load_err}), 32'd0);
    load_start = 1'b1;
    tick();
    chk("t5_reset_priority", 32'(state_o), 32'(S_IDLE));
    reset      = 1'b0;
    load_start = 1'b0;
    repeat (3) tick();
    chk("t5_stays_idle", 32'(state_o), 32'(S_IDLE));
    chk("t5_writes", 32'(n_writes - w0), 32'd2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jimmy_prog_loader.md
JIMMY_PROG_LOADER -- requirements
Module: jimmy_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, 8, program memory address width.
REQ-002 SHALL have parameter DATA_W, 8, instruction byte width.
REQ-003 SHALL have parameter TIMEOUT, 255, idle cycles allowed between accepted bytes.
REQ-004 SHALL have parameter RELEASE_CYCLES, 4, cycles the CPU is held after a good load.
REQ-005 SHALL have port jimmy_clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port load_start  in  1  one-cycle request to begin a load.
REQ-008 SHALL have port load_len  in  ADDR_W  number of program bytes (0 means 256).
REQ-009 SHALL have port byte_in  in  DATA_W  incoming program/checksum byte.
REQ-010 SHALL have port byte_valid  in  1  byte_in is valid.
REQ-011 SHALL have port byte_ready  out  1  loader accepts byte_in this cycle.
REQ-012 SHALL have port pm_we  out  1  program memory write strobe.
REQ-013 SHALL have port pm_addr  out  ADDR_W  program memory write address.
REQ-014 SHALL have port pm_wdata  out  DATA_W  program memory write data.
REQ-015 SHALL have port cpu_run  out  1  high = Jimmy may execute; low = Jimmy held.
REQ-016 SHALL have port load_done  out  1  last load passed checksum.
REQ-017 SHALL have port load_err  out  1  last load failed (checksum or timeout).
REQ-018 SHALL have port state_o  out  3  current FSM state encoding.

Function
REQ-019 SHALL implement states IDLE, LOAD, CHECK, RELEASE, RUN, ERROR.
REQ-020 SHALL, in IDLE/RUN/ERROR on load_start, latch load_len, clear address, byte count, checksum and timeout, clear load_done/load_err, drive cpu_run low next cycle, enter LOAD.
REQ-021 SHALL ignore load_start in LOAD, CHECK and RELEASE.
REQ-022 SHALL drive byte_ready high only in LOAD and CHECK; a byte transfers when byte_valid and byte_ready are both high.
REQ-023 SHALL, on each LOAD transfer, assert pm_we for exactly the following cycle with pm_addr = current address and pm_wdata = byte_in (1-cycle registered latency), then increment address.
REQ-024 SHALL accumulate checksum as the 8-bit modulo-256 sum of all LOAD bytes.
REQ-025 SHALL enter CHECK after the load_len-th transfer (256th when load_len = 0); address wraps 255->0 without error.
REQ-026 SHALL, in CHECK, accept one byte without writing memory; equal to checksum -> RELEASE, else ERROR.
REQ-027 SHALL count idle cycles in LOAD/CHECK, clear the count on every transfer, and enter ERROR when the count reaches TIMEOUT.
REQ-028 SHALL hold cpu_run low for exactly RELEASE_CYCLES cycles in RELEASE, then enter RUN.
REQ-029 SHALL drive cpu_run high only in RUN; load_done set on entry to RUN; load_err set on entry to ERROR; both held until the next load_start.
REQ-030 SHALL keep pm_we low in every state other than the cycle after a LOAD transfer.

Reset
REQ-031 SHALL on reset enter IDLE with cpu_run=0, byte_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, load_done=0, load_err=0, all counters and checksum 0.
REQ-032 SHALL abort a load in progress on reset mid-operation with no further pm_we pulses.
REQ-033 SHALL give reset priority over load_start in the same cycle.

Structure
REQ-034 SHALL take state encodings and default parameter values from a shared package jimmy_loader_pkg.
REQ-035 SHALL place the timeout/release counter in one sub-module jimmy_loader_timer (load, clear, terminal-count output).
REQ-036 SHALL use no other sub-modules; FSM and datapath in jimmy_prog_loader.

Verification
REQ-037 SHALL verify: load_len=3, bytes 01,02,03, checksum 06 -> three pm_we pulses at addr 0,1,2; RELEASE for 4 cycles; cpu_run=1, load_done=1.
REQ-038 SHALL verify: same load with checksum 07 -> no RUN, load_err=1, cpu_run=0.
REQ-039 SHALL verify: byte_valid withheld 255 cycles after the 2nd byte -> ERROR, load_err=1, no further pm_we.
REQ-040 SHALL verify: load_len=0, 256 bytes of 01, checksum 00 -> addresses 0..255 written once each, RUN reached.
REQ-041 SHALL verify: reset asserted after 2nd byte of a 5-byte load -> IDLE next cycle, all outputs at reset values.
REQ-042 SHALL verify: load_start pulsed during LOAD is ignored; load_start in RUN restarts load with cpu_run=0 next cycle.
